// File: rtl/prll_bs_pkg.sv
// Shared definitions for the parallel bus arbiters: message field layout,
// broadcast encoding and the sequencer state type.
package prll_bs_pkg;

    localparam logic [7:0] BROADCAST_DFLT = 8'hFF;

    // Field positions measured down from the message MSB
    localparam int FIELD_W          = 8;
    localparam int TGT_LSB_FROM_TOP = 8;
    localparam int SRC_LSB_FROM_TOP = 16;
    localparam int ID_LSB_FROM_TOP  = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_DECODE,
        S_PUSH
    } bs_state_t;

endpackage

// File: rtl/prll_bs_rr_rbtr_if.sv
// Driver-side bus of one arbiter: FIFO heads and status in, pop/push strobes
// and the shared push data out.
interface prll_bs_rr_rbtr_if #(
    parameter int BITS  = 32,
    parameter int DRVRS = 4
);
    logic [DRVRS-1:0]           pndng;
    logic [DRVRS-1:0][BITS-1:0] D_pop;
    logic [DRVRS-1:0]           full;
    logic [DRVRS-1:0]           pop;
    logic [DRVRS-1:0]           push;
    logic [BITS-1:0]            D_push;

    modport master (
        input  pndng, D_pop, full,
        output pop, push, D_push
    );

    modport slave (
        output pndng, D_pop, full,
        input  pop, push, D_push
    );
endinterface

// File: rtl/prll_bs_rr_rbtr_rr_pick.sv
// Combinational round-robin priority encoder: first request after the last
// grant, wrapping around.
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [W-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(last) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/prll_bs_rr_rbtr.sv
// Round-robin arbiter/sequencer for one bus: pops the winning driver's head
// message, decodes its target and pushes it to one driver or broadcasts it.
module prll_bs_rr_rbtr
    import prll_bs_pkg::*;
#(
    parameter  int         BITS      = 32,
    parameter  int         DRVRS     = 4,
    parameter  logic [7:0] BROADCAST = BROADCAST_DFLT,
    localparam int         GW        = $clog2(DRVRS)
) (
    input  logic                 clk,
    input  logic                 reset,
    prll_bs_rr_rbtr_if.master    bus,
    output logic [GW-1:0]        grant,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);

    localparam logic [7:0] DRVRS_B = 8'(DRVRS);

    bs_state_t         state;
    logic [BITS-1:0]   held;
    logic [DRVRS-1:0]  mask;
    logic [DRVRS-1:0]  dest_mask;
    logic              tgt_valid;
    logic [7:0]        tgt;
    logic [7:0]        src;
    logic [GW-1:0]     pick_idx;
    logic              pick_valid;
    logic              start_pop;

    assign tgt  = held[BITS-TGT_LSB_FROM_TOP +: FIELD_W];
    assign src  = held[BITS-SRC_LSB_FROM_TOP +: FIELD_W];
    assign busy = (state != S_IDLE);

    rr_pick #(.N(DRVRS)) u_pick (
        .req   (bus.pndng),
        .last  (grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // A new winner may be taken from IDLE or straight out of a completed push
    assign start_pop = pick_valid &&
                       ((state == S_IDLE) || ((state == S_PUSH) && (bus.push != '0)));

    // Broadcast with an out-of-range source has nobody to exclude
    always_comb begin
        dest_mask = '0;
        tgt_valid = 1'b0;
        if (tgt == BROADCAST) begin
            tgt_valid = 1'b1;
            dest_mask = '1;
            if (src < DRVRS_B)
                dest_mask[src[GW-1:0]] = 1'b0;
        end else if (tgt < DRVRS_B) begin
            tgt_valid = 1'b1;
            dest_mask[tgt[GW-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            bus.pop    <= '0;
            bus.push   <= '0;
            bus.D_push <= '0;
            grant      <= GW'(DRVRS-1);
            drop_cnt   <= '0;
            held       <= '0;
            mask       <= '0;
        end else begin
            bus.pop  <= '0;
            bus.push <= '0;
            if (start_pop) begin
                state   <= S_POP;
                bus.pop <= DRVRS'(1) << pick_idx;
                grant   <= pick_idx;
                held    <= bus.D_pop[pick_idx];
            end else begin
                unique case (state)
                    S_IDLE:   state <= S_IDLE;
                    S_POP:    state <= S_DECODE;
                    S_DECODE: begin
                        if (!tgt_valid) begin
                            if (drop_cnt != 16'hFFFF)
                                drop_cnt <= drop_cnt + 16'd1;
                            state <= S_IDLE;
                        end else begin
                            mask       <= dest_mask;
                            bus.D_push <= held;
                            state      <= S_PUSH;
                            if ((bus.full & dest_mask) == '0)
                                bus.push <= dest_mask;
                        end
                    end
                    // Stay here stalled until every masked driver can accept at once
                    S_PUSH: begin
                        if (bus.push != '0)
                            state <= S_IDLE;
                        else if ((bus.full & mask) == '0)
                            bus.push <= mask;
                    end
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prll_bs_rr_rbtr.sv
// Self-checking bench for prll_bs_rr_rbtr: driver FIFOs emulated with queues,
// a transaction-level scoreboard checked every cycle, plus directed literals.
module tb_prll_bs_rr_rbtr;

    localparam int N    = 4;
    localparam int BITS = 32;
    localparam int INF  = 32'h7fffffff;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] drop_cnt;

    prll_bs_rr_rbtr_if #(.BITS(BITS), .DRVRS(N)) bus ();

    prll_bs_rr_rbtr #(.BITS(BITS), .DRVRS(N), .BROADCAST(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant    (grant),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    bit          check_en = 0;
    logic [31:0] fifo [N][$];
    logic [3:0]  full_vec = '0;
    logic [3:0]  drv_pndng, drv_full;
    logic [31:0] drv_head [N];

    int          model_grant, avail, drop_due;
    logic [15:0] model_drop;
    bit          prev_sel_ok;
    exp_t        expq[$];

    int          pops_per [N];
    int          pop_log[$];
    int          push_count = 0;
    int          last_pop_cyc = -1, last_push_cyc = -1;
    logic [3:0]  last_pop_vec, last_push_vec;
    logic [31:0] last_push_data;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rrModel(logic [3:0] req, int last);
        for (int k = 1; k <= N; k++)
            if (req[2'((last + k) % N)]) return (last + k) % N;
        return -1;
    endfunction

    function automatic void decodeModel(input logic [31:0] m, output logic [3:0] mask, output bit vld);
        logic [7:0] t = m[31:24];
        logic [7:0] s = m[23:16];
        vld  = 1'b1;
        mask = '0;
        if (t == 8'hFF)  mask = (s < 8'd4) ? (4'hF & ~(4'b0001 << s)) : 4'hF;
        else if (t < 8'd4) mask = 4'b0001 << t;
        else vld = 1'b0;
    endfunction

    task automatic initModel();
        model_grant = N - 1;
        model_drop  = '0;
        avail       = 0;
        drop_due    = -1;
        prev_sel_ok = 1'b1;
        expq.delete();
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            drv_pndng[2'(i)] = (fifo[i].size() != 0);
            drv_head[i]      = (fifo[i].size() != 0) ? fifo[i][0] : 32'h0;
        end
        drv_full   = full_vec;
        bus.pndng  = drv_pndng;
        bus.D_pop  = {drv_head[3], drv_head[2], drv_head[1], drv_head[0]};
        bus.full   = drv_full;
    endtask

    task automatic checkOutput();
        logic [3:0]  p, pu, expm;
        logic [31:0] msg;
        bit          vld, push_now, exp_push;
        int          w;
        p        = bus.pop;
        pu       = bus.push;
        push_now = 1'b0;
        w        = 0;
        chk("pop_onehot", 64'($countones(p) <= 1), 1);
        chk("pop_push_excl", 64'((p != 0) && (pu != 0)), 0);
        if (cyc == drop_due)
            model_drop = (model_drop == 16'hFFFF) ? 16'hFFFF : model_drop + 16'd1;
        chk("pop_timing", 64'(p != 0), 64'((drv_pndng != 0) && prev_sel_ok));
        if (p != 0) begin
            for (int i = 0; i < N; i++) if (p[2'(i)]) w = i;
            chk("rr_winner", w, rrModel(drv_pndng, model_grant));
            model_grant = w;
            pops_per[w]++;
            pop_log.push_back(w);
            last_pop_cyc = cyc;
            last_pop_vec = p;
            msg = drv_head[w];
            decodeModel(msg, expm, vld);
            if (vld) begin
                expq.push_back('{data: msg, mask: expm, due: cyc + 2});
                avail = INF;
            end else begin
                drop_due = cyc + 2;
                avail    = cyc + 2;
            end
        end
        if (expq.size() != 0 && cyc >= expq[0].due) begin
            exp_push = ((drv_full & expq[0].mask) == 0);
            chk("push_timing", 64'(pu != 0), 64'(exp_push));
            if (pu != 0) begin
                chk("push_mask", pu, expq[0].mask);
                chk("push_data", bus.D_push, expq[0].data);
                push_now       = 1'b1;
                avail          = cyc;
                last_push_cyc  = cyc;
                last_push_vec  = pu;
                last_push_data = bus.D_push;
                push_count++;
                void'(expq.pop_front());
            end else begin
                chk("held_data_stable", bus.D_push, expq[0].data);
            end
        end else begin
            chk("no_spurious_push", pu, 0);
        end
        chk("busy", busy, 64'((cyc < avail) || push_now));
        chk("grant", grant, model_grant);
        chk("drop_cnt", drop_cnt, model_drop);
        prev_sel_ok = (cyc >= avail);
    endtask

    task automatic stepCycle();
        applyStimulus();
        @(negedge clk);
        cyc++;
        if (check_en) checkOutput();
        for (int i = 0; i < N; i++)
            if (bus.pop[2'(i)] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    endtask

    function automatic bit idleNow();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (fifo[i].size() != 0) e = 1'b0;
        return e && (expq.size() == 0) && !busy;
    endfunction

    task automatic runUntilIdle(int maxc);
        int n = 0;
        while (!idleNow() && n < maxc) begin stepCycle(); n++; end
        chk("idle_reached", 64'(idleNow()), 1);
    endtask

    task automatic waitPop(int maxc);
        int n = 0;
        do begin stepCycle(); n++; end while (last_pop_cyc != cyc && n < maxc);
        chk("pop_seen", 64'(last_pop_cyc == cyc), 1);
    endtask

    task automatic waitPush(int maxc);
        int n = 0;
        do begin stepCycle(); n++; end while (last_push_cyc != cyc && n < maxc);
        chk("push_seen", 64'(last_push_cyc == cyc), 1);
    endtask

    initial begin
        int          n, c0, pc;
        logic [15:0] id_ctr;
        initModel();
        for (int i = 0; i < N; i++) pops_per[i] = 0;
        repeat (3) stepCycle();
        chk("reset_pop", bus.pop, 0);
        chk("reset_push", bus.push, 0);
        chk("reset_D_push", bus.D_push, 0);
        chk("reset_grant", grant, 3);
        chk("reset_busy", busy, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        reset    = 1'b1;
        check_en = 1'b1;

        // All drivers pending continuously
        id_ctr = '0;
        n = 0;
        while (push_count < 1024 && n < 4000) begin
            for (int i = 0; i < N; i++)
                while (fifo[i].size() < 2) begin
                    fifo[i].push_back({8'((i + 1) % N), 8'(i), id_ctr});
                    id_ctr++;
                end
            stepCycle();
            n++;
        end
        chk("rr_push_total", push_count, 1024);
        for (int i = 0; i < N; i++) chk("rr_pops_per_driver", pops_per[i], 256);
        chk("rr_log_len", 64'(pop_log.size() >= 8), 1);
        for (int i = 0; i < 8 && i < pop_log.size(); i++) chk("rr_order", pop_log[i], i % 4);
        runUntilIdle(200);

        // Single request
        c0 = cyc;
        fifo[2].push_back(32'h0002_0001);
        runUntilIdle(20);
        chk("single_pop_cycle", last_pop_cyc - c0, 1);
        chk("single_pop_vec", last_pop_vec, 4'b0100);
        chk("single_push_cycle", last_push_cyc - c0, 3);
        chk("single_push_vec", last_push_vec, 4'b0001);
        chk("single_push_data", last_push_data, 32'h0002_0001);
        chk("single_grant", grant, 2);

        // Broadcasts and unicast to self
        fifo[1].push_back(32'hFF01_00B1);
        runUntilIdle(20);
        chk("bcast_vec", last_push_vec, 4'b1101);
        chk("bcast_data", last_push_data, 32'hFF01_00B1);
        fifo[3].push_back(32'hFF07_00B2);
        runUntilIdle(20);
        chk("bcast_badsrc_vec", last_push_vec, 4'b1111);
        fifo[2].push_back(32'h0202_00C3);
        runUntilIdle(20);
        chk("self_vec", last_push_vec, 4'b0100);

        // Invalid target, then saturation
        pc = push_count;
        fifo[1].push_back(32'h0901_0055);
        runUntilIdle(20);
        chk("drop_first", drop_cnt, 16'd1);
        chk("drop_no_push", push_count, pc);
        force dut.drop_cnt = 16'hFFFF;
        model_drop = 16'hFFFF;
        stepCycle();
        release dut.drop_cnt;
        stepCycle();
        fifo[1].push_back(32'h0901_0056);
        runUntilIdle(20);
        chk("drop_saturated", drop_cnt, 16'hFFFF);

        // Backpressure on driver 3
        full_vec = 4'b1000;
        fifo[0].push_back(32'h0300_00D4);
        waitPop(20);
        repeat (6) stepCycle();
        full_vec = 4'b0000;
        waitPush(20);
        chk("bp_latency", last_push_cyc - last_pop_cyc, 7);
        chk("bp_vec", last_push_vec, 4'b1000);
        chk("bp_data", last_push_data, 32'h0300_00D4);
        runUntilIdle(20);

        // Reset during a push
        fifo[1].push_back(32'h0001_00E5);
        waitPop(20);
        fifo[0].push_back(32'h0300_00E6);
        fifo[2].push_back(32'h0102_00E7);
        waitPush(20);
        reset = 1'b0;
        #1;
        chk("midreset_push", bus.push, 0);
        chk("midreset_pop", bus.pop, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_grant", grant, 3);
        chk("midreset_drop_cnt", drop_cnt, 0);
        check_en = 1'b0;
        initModel();
        repeat (2) stepCycle();
        reset    = 1'b1;
        check_en = 1'b1;
        waitPop(10);
        chk("post_reset_first_pop", last_pop_vec, 4'b0001);
        runUntilIdle(50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/prll_bs_rr_rbtr.md
# prll_bs_rr_rbtr

Round-robin arbiter and sequencer for one bus of the parallel bus system. It grants one of `DRVRS` drivers with pending messages and pops that driver's message. It then decodes the 8-bit target field and pushes the message to the target driver, or to every other driver on broadcast. One instance per bus; `BUSES` instances sit side by side inside the parallel bus generator.

## Interface
Parameters:
- `BITS`, 32: message width; minimum 32.
- `DRVRS`, 4: drivers on this bus; 2..254.
- `BROADCAST`, 8'hFF: target value meaning "all drivers except source".

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `pndng`, in, `DRVRS`: driver i's FIFO holds a message; show-ahead, so `D_pop[i]` is valid while `pndng[i]`=1.
- `D_pop`, in, `DRVRS`×`BITS`: head message per driver. Format: [BITS-1:BITS-8] target, [BITS-9:BITS-16] source, [BITS-17:BITS-32] ID.
- `full`, in, `DRVRS`: driver i cannot accept a push this cycle.
- `pop`, out, `DRVRS`: one-hot pop strobe, registered.
- `push`, out, `DRVRS`: push strobe(s), registered; one-hot, or multi-hot on broadcast.
- `D_push`, out, `BITS`: message shared by all drivers, registered; valid while any `push` bit is 1.
- `grant`, out, $clog2(DRVRS): last granted driver.
- `busy`, out, 1: FSM not in IDLE.
- `drop_cnt`, out, 16: count of messages dropped for an invalid target; saturates at 16'hFFFF.

## Operation
- FSM states:
  - IDLE: if any `pndng`, choose the winner, go to POP; else stay.
  - POP: `pop[winner]`=1 for exactly one cycle. `D_pop[winner]` is captured into the holding register on the same edge. Go to DECODE.
  - DECODE: the target is valid if it is < `DRVRS` or equals `BROADCAST`.
    - Invalid target: increment `drop_cnt`, go to IDLE.
    - Valid target: compute the destination mask, go to PUSH.
  - PUSH: wait until `full` & mask == 0. Then assert `push`=mask and `D_push`=held message for one cycle. Next: POP with a new winner if any `pndng`, else IDLE.
- Destination mask:
  - Unicast: bit[target].
  - Broadcast: all ones except bit[source field].
  - A source field ≥ `DRVRS` on broadcast: push to all drivers.
- Unicast to self (target == source) is legal and pushed normally.
- Round-robin selection:
  - Search starts at (`grant`+1) mod `DRVRS` and takes the first `pndng` bit, with wrap-around.
  - `grant` updates on entry to POP.
- `pndng` is sampled at selection time only. A driver dropping `pndng` afterwards does not abort the message.
- Messages are forwarded unmodified; no ID checking.

## Timing
- Reset values:
  - `pop`, `push`, `D_push`: 0.
  - `grant`: `DRVRS`-1, so driver 0 has first priority.
  - `busy`, `drop_cnt`: 0.
  - FSM: IDLE.
- Latency, with no backpressure:
  - `pndng` rises at edge N: `pop` is high in cycle N+1 and `push` in cycle N+3.
  - Back-to-back messages: one every 3 cycles (POP→DECODE→PUSH→POP).
- `full` stalls PUSH indefinitely. The held message is not lost and `D_push` stays stable. No partial broadcast: all masked targets are pushed in the same cycle.
- Reset asserted mid-operation: all outputs clear asynchronously. The held message is discarded; it was already popped, so it is lost by design.
- Never more than one `pop` bit per cycle. `pop` and `push` are never high in the same cycle.

## Structure
- Shared package `prll_bs_pkg` holds:
  - `BROADCAST` default;
  - field offset constants for target, source and ID;
  - the FSM state enum `bs_state_t`.
- One sub-module, `rr_pick`: combinational round-robin priority encoder. Inputs: request vector and last grant. Outputs: winner index and valid.

## Test plan
- Single request: `pndng`=4'b0100, `D_pop[2]`={8'd0,8'd2,16'h0001} → `pop[2]` in cycle 1, `push`=4'b0001 with that message in cycle 3. `grant`=2.
- All pending continuously, messages {i+1 mod 4, i, counter} → pop order 0,1,2,3,0…. After 1024 pushes, each driver has popped 256 messages.
- Broadcast from driver 1 (target 8'hFF, source 1) → `push`=4'b1101 in one cycle, identical `D_push`.
- Backpressure: unicast to driver 3 with `full[3]`=1 for 5 cycles → `push` held low for 5 cycles, then `push[3]` pulses once with the unchanged message.
- Invalid target 8'd9 with `DRVRS`=4 → no `push`, `drop_cnt` 0→1, FSM returns to IDLE. Forcing `drop_cnt` to 16'hFFFF and repeating leaves it saturated at 16'hFFFF.
- Drive `reset`=0 during PUSH → `push`, `pop` and `busy` go to 0 immediately. After release, driver 0 has first priority.
